// File: rtl/lamp_pkg.sv
// ============================================================================
//  Module   : lamp_pkg
//  Brief    : Lamp codes, monitor state encoding and lamp-code helper functions
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lamp_pkg;

  localparam logic [2:0] c_RED    = 3'b100;
  localparam logic [2:0] c_GREEN  = 3'b010;
  localparam logic [2:0] c_YELLOW = 3'b001;

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } mon_state_t;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == c_RED) || (code == c_GREEN) || (code == c_YELLOW);
  endfunction

  // Successor in the R->G->Y->R cycle; illegal codes have no successor.
  function automatic logic [2:0] next_colour(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      c_RED:    nxt = c_GREEN;
      c_GREEN:  nxt = c_YELLOW;
      c_YELLOW: nxt = c_RED;
      default:  nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lamp_seq_checker.sv
// ============================================================================
//  Module   : lamp_seq_checker
//  Brief    : Classifies one lamp sample against its predecessor
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lamp_seq_checker
  import lamp_pkg::*;
(
  input  logic [2:0] i_light_q,
  input  logic [2:0] i_prev_q,
  input  logic       i_prev_vld,
  output logic       o_is_trans,
  output logic       o_seq_err,
  output logic       o_illegal
);

  logic w_cur_legal;
  logic w_prev_legal;

  assign w_cur_legal  = is_legal(i_light_q);
  assign w_prev_legal = is_legal(i_prev_q);

  assign o_illegal  = !w_cur_legal;
  // Only legal-to-legal changes count; anything touching an illegal code is skipped.
  assign o_is_trans = i_prev_vld && w_cur_legal && w_prev_legal && (i_light_q != i_prev_q);
  assign o_seq_err  = o_is_trans && (i_light_q != next_colour(i_prev_q));

endmodule

`default_nettype wire

// File: rtl/lamp_power_monitor.sv
// ============================================================================
//  Module   : lamp_power_monitor
//  Brief    : Per-colour on-time, transition and energy accounting with
//             windowed valid/ready reports and sticky error flags
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lamp_power_monitor
  import lamp_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ENERGY_W = 32,
  parameter int P_RED    = 12,
  parameter int P_GREEN  = 10,
  parameter int P_YELLOW = 6,
  parameter int WINDOW   = 1000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          light,
  input  logic                clear,
  input  logic                rpt_ready,
  output logic                rpt_valid,
  output logic [CNT_W-1:0]    rpt_red,
  output logic [CNT_W-1:0]    rpt_green,
  output logic [CNT_W-1:0]    rpt_yellow,
  output logic [CNT_W-1:0]    rpt_trans,
  output logic [ENERGY_W-1:0] rpt_energy,
  output logic                err_illegal,
  output logic                err_seq,
  output logic                err_overrun
);

  localparam int              WIN_W      = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] c_WIN_LAST = WIN_W'(WINDOW - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  mon_state_t r_state;
  mon_state_t w_state_nxt;

  logic [2:0]          r_light_q;
  logic                r_light_q_vld;
  logic [2:0]          r_prev_q;
  logic                r_prev_vld;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [CNT_W-1:0]    r_acc_red, r_acc_green, r_acc_yellow, r_acc_trans;
  logic [ENERGY_W-1:0] r_acc_energy;

  logic                r_rpt_valid;
  logic [CNT_W-1:0]    r_rpt_red, r_rpt_green, r_rpt_yellow, r_rpt_trans;
  logic [ENERGY_W-1:0] r_rpt_energy;
  logic                r_err_illegal, r_err_seq, r_err_overrun;

  logic                w_run;
  logic                w_is_trans, w_seq_err, w_illegal;
  logic                w_is_red, w_is_green, w_is_yellow;
  logic                w_win_end, w_accept;
  logic [CNT_W-1:0]    w_red_nxt, w_green_nxt, w_yellow_nxt, w_trans_nxt;
  logic [ENERGY_W-1:0] w_pwr;
  logic [ENERGY_W:0]   w_energy_sum;
  logic [ENERGY_W-1:0] w_energy_nxt;

  lamp_seq_checker u_seq_checker (
    .i_light_q  (r_light_q),
    .i_prev_q   (r_prev_q),
    .i_prev_vld (r_prev_vld),
    .o_is_trans (w_is_trans),
    .o_seq_err  (w_seq_err),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_light_q     <= 3'b000;
      r_light_q_vld <= 1'b0;
    end else begin
      r_light_q     <= light;
      r_light_q_vld <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_WARM;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WARM: if (r_light_q_vld) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_WARM;
    endcase
    if (clear) w_state_nxt = ST_WARM;
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_is_red    = w_run && (r_light_q == c_RED);
  assign w_is_green  = w_run && (r_light_q == c_GREEN);
  assign w_is_yellow = w_run && (r_light_q == c_YELLOW);

  assign w_red_nxt    = sat_inc(r_acc_red,    w_is_red);
  assign w_green_nxt  = sat_inc(r_acc_green,  w_is_green);
  assign w_yellow_nxt = sat_inc(r_acc_yellow, w_is_yellow);
  assign w_trans_nxt  = sat_inc(r_acc_trans,  w_run && w_is_trans);

  always_comb begin
    w_pwr = '0;
    if (w_is_red)         w_pwr = ENERGY_W'(P_RED);
    else if (w_is_green)  w_pwr = ENERGY_W'(P_GREEN);
    else if (w_is_yellow) w_pwr = ENERGY_W'(P_YELLOW);
  end

  assign w_energy_sum = {1'b0, r_acc_energy} + {1'b0, w_pwr};
  assign w_energy_nxt = w_energy_sum[ENERGY_W] ? '1 : w_energy_sum[ENERGY_W-1:0];

  assign w_win_end = w_run && (r_win_cnt == c_WIN_LAST);
  assign w_accept  = r_rpt_valid && rpt_ready;

  // Accumulators restart after a window end, but prev_q carries over.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_win_cnt    <= '0;
      r_acc_red    <= '0;
      r_acc_green  <= '0;
      r_acc_yellow <= '0;
      r_acc_trans  <= '0;
      r_acc_energy <= '0;
      r_prev_q     <= 3'b000;
      r_prev_vld   <= 1'b0;
    end else if (w_run) begin
      r_prev_q   <= r_light_q;
      r_prev_vld <= 1'b1;
      if (w_win_end) begin
        r_win_cnt    <= '0;
        r_acc_red    <= '0;
        r_acc_green  <= '0;
        r_acc_yellow <= '0;
        r_acc_trans  <= '0;
        r_acc_energy <= '0;
      end else begin
        r_win_cnt    <= r_win_cnt + WIN_W'(1);
        r_acc_red    <= w_red_nxt;
        r_acc_green  <= w_green_nxt;
        r_acc_yellow <= w_yellow_nxt;
        r_acc_trans  <= w_trans_nxt;
        r_acc_energy <= w_energy_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rpt_valid   <= 1'b0;
      r_rpt_red     <= '0;
      r_rpt_green   <= '0;
      r_rpt_yellow  <= '0;
      r_rpt_trans   <= '0;
      r_rpt_energy  <= '0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_overrun <= 1'b0;
    end else if (clear) begin
      r_rpt_valid   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_run && w_illegal) r_err_illegal <= 1'b1;
      if (w_run && w_seq_err) r_err_seq     <= 1'b1;
      // A pending unaccepted report wins; the fresh snapshot is dropped.
      if (w_win_end && (!r_rpt_valid || w_accept)) begin
        r_rpt_valid  <= 1'b1;
        r_rpt_red    <= w_red_nxt;
        r_rpt_green  <= w_green_nxt;
        r_rpt_yellow <= w_yellow_nxt;
        r_rpt_trans  <= w_trans_nxt;
        r_rpt_energy <= w_energy_nxt;
      end else if (w_win_end) begin
        r_err_overrun <= 1'b1;
      end else if (w_accept) begin
        r_rpt_valid <= 1'b0;
      end
    end
  end

  assign rpt_valid   = r_rpt_valid;
  assign rpt_red     = r_rpt_red;
  assign rpt_green   = r_rpt_green;
  assign rpt_yellow  = r_rpt_yellow;
  assign rpt_trans   = r_rpt_trans;
  assign rpt_energy  = r_rpt_energy;
  assign err_illegal = r_err_illegal;
  assign err_seq     = r_err_seq;
  assign err_overrun = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lamp_power_monitor.sv
// ============================================================================
//  Module   : tb_lamp_power_monitor
//  Brief    : Directed-vector bench for lamp_power_monitor (WINDOW=6) plus a
//             saturation instance (CNT_W=4, WINDOW=20)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lamp_power_monitor;

  logic        clock;
  logic        reset_n;
  logic [2:0]  light;
  logic        clear;
  logic        rpt_ready;
  logic        rpt_valid;
  logic [15:0] rpt_red, rpt_green, rpt_yellow, rpt_trans;
  logic [31:0] rpt_energy;
  logic        err_illegal, err_seq, err_overrun;

  logic [2:0]  s_light;
  logic        s_clear;
  logic        s_ready;
  logic        s_valid;
  logic [3:0]  s_red, s_green, s_yellow, s_trans;
  logic [31:0] s_energy;
  logic        s_err_illegal, s_err_seq, s_err_overrun;

  int n_checks = 0;
  int n_errors = 0;

  lamp_power_monitor #(.WINDOW(6)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .light       (light),
    .clear       (clear),
    .rpt_ready   (rpt_ready),
    .rpt_valid   (rpt_valid),
    .rpt_red     (rpt_red),
    .rpt_green   (rpt_green),
    .rpt_yellow  (rpt_yellow),
    .rpt_trans   (rpt_trans),
    .rpt_energy  (rpt_energy),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_overrun (err_overrun)
  );

  lamp_power_monitor #(.CNT_W(4), .WINDOW(20)) u_sat (
    .clock       (clock),
    .reset_n     (reset_n),
    .light       (s_light),
    .clear       (s_clear),
    .rpt_ready   (s_ready),
    .rpt_valid   (s_valid),
    .rpt_red     (s_red),
    .rpt_green   (s_green),
    .rpt_yellow  (s_yellow),
    .rpt_trans   (s_trans),
    .rpt_energy  (s_energy),
    .err_illegal (s_err_illegal),
    .err_seq     (s_err_seq),
    .err_overrun (s_err_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Lamp code driven during cycle k (the cycle following edge k).
  function automatic logic [2:0] light_for(input int k);
    logic [2:0] seq [3];
    seq[0] = 3'b100; seq[1] = 3'b010; seq[2] = 3'b001;
    if (k <= 12)      return seq[(k - 1) % 3];
    else if (k <= 18) return 3'b100;
    else if (k <= 21) return 3'b010;
    else if (k <= 24) return 3'b001;
    else if (k == 25) return 3'b100;
    else if (k == 26) return 3'b111;
    else if (k == 27) return 3'b100;
    else if (k == 28) return 3'b001;
    else if (k == 29) return 3'b100;
    else if (k <= 37) return 3'b010;
    else if (k <= 39) return 3'b100;
    else if (k <= 41) return 3'b010;
    else              return 3'b001;
  endfunction

  task automatic chk_rpt(input string tag, input int r, input int g, input int y,
                         input int t, input int e);
    chk({tag, "_valid"},  {31'd0, rpt_valid}, 32'd1);
    chk({tag, "_red"},    {16'd0, rpt_red},    r);
    chk({tag, "_green"},  {16'd0, rpt_green},  g);
    chk({tag, "_yellow"}, {16'd0, rpt_yellow}, y);
    chk({tag, "_trans"},  {16'd0, rpt_trans},  t);
    chk({tag, "_energy"}, rpt_energy,          e);
  endtask

  task automatic chk_err(input string tag, input logic il, input logic sq, input logic ov);
    chk({tag, "_err_illegal"}, {31'd0, err_illegal}, {31'd0, il});
    chk({tag, "_err_seq"},     {31'd0, err_seq},     {31'd0, sq});
    chk({tag, "_err_overrun"}, {31'd0, err_overrun}, {31'd0, ov});
  endtask

  initial begin
    reset_n   = 1'b0;
    light     = 3'b100;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    s_light   = 3'b100;
    s_clear   = 1'b0;
    s_ready   = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid",  {31'd0, rpt_valid}, 32'd0);
    chk("rst_red",    {16'd0, rpt_red},   32'd0);
    chk("rst_green",  {16'd0, rpt_green}, 32'd0);
    chk("rst_yellow", {16'd0, rpt_yellow},32'd0);
    chk("rst_trans",  {16'd0, rpt_trans}, 32'd0);
    chk("rst_energy", rpt_energy,         32'd0);
    chk_err("rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int k = 1; k <= 56; k++) begin
      @(posedge clock);
      #1;
      case (k)
        7:  chk("win1_early_valid", {31'd0, rpt_valid}, 32'd0);
        8:  begin
              chk_rpt("win1", 2, 2, 2, 5, 56);
              chk_err("win1", 1'b0, 1'b0, 1'b0);
            end
        9:  chk("accept1_valid", {31'd0, rpt_valid}, 32'd0);
        14: chk_rpt("win2", 2, 2, 2, 6, 56);
        20: begin
              chk_rpt("held", 2, 2, 2, 6, 56);
              chk_err("held", 1'b0, 1'b0, 1'b1);
            end
        21: chk("sat_early_valid", {31'd0, s_valid}, 32'd0);
        22: begin
              chk("sat_valid",  {31'd0, s_valid},  32'd1);
              chk("sat_red",    {28'd0, s_red},    32'd15);
              chk("sat_green",  {28'd0, s_green},  32'd0);
              chk("sat_trans",  {28'd0, s_trans},  32'd0);
              chk("sat_energy", s_energy,          32'd240);
            end
        26: begin
              chk_rpt("acc_win_end", 0, 3, 3, 2, 48);
              chk("acc_win_end_overrun", {31'd0, err_overrun}, 32'd1);
            end
        27: chk("accept4_valid", {31'd0, rpt_valid}, 32'd0);
        28: begin
              chk("illegal_set",    {31'd0, err_illegal}, 32'd1);
              chk("seq_still_zero", {31'd0, err_seq},     32'd0);
            end
        30: chk("seq_set", {31'd0, err_seq}, 32'd1);
        32: begin
              chk_rpt("win5", 3, 1, 1, 4, 52);
              chk_err("win5", 1'b1, 1'b1, 1'b1);
            end
        38: begin
              chk("clr_end_valid", {31'd0, rpt_valid}, 32'd0);
              chk_err("clr_end", 1'b0, 1'b0, 1'b0);
            end
        44: chk("post_clr_early_valid", {31'd0, rpt_valid}, 32'd0);
        45: begin
              chk_rpt("post_clr", 2, 2, 2, 2, 56);
              chk_err("post_clr", 1'b0, 1'b0, 1'b0);
            end
        46: chk("accept7_valid", {31'd0, rpt_valid}, 32'd0);
        54: chk("mid_clr_early_valid", {31'd0, rpt_valid}, 32'd0);
        55: chk_rpt("mid_clr", 0, 0, 6, 0, 36);
        default: ;
      endcase
      light     = light_for(k);
      rpt_ready = (k == 8) || (k == 25) || (k == 26) || (k == 37) || (k == 45);
      clear     = (k == 37) || (k == 47);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
